// File: rtl/up_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, A-source selects and default widths.
// Used by both the datapath and the control unit.
package up_pkg;

  localparam int DW = 8;
  localparam int AW = 5;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_INPUT = 3'b100,
    OP_JZ    = 3'b101,
    OP_JPOS  = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ASEL_ALU  = 2'b00,
    ASEL_IN   = 2'b01,
    ASEL_MEM  = 2'b10,
    ASEL_ZERO = 2'b11
  } asel_t;

  // Subtraction overflows when operand signs differ, addition when they match,
  // and in both cases only if the result sign departs from A's sign.
  function automatic logic add_sub_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                       input logic [DW-1:0] r, input logic sub);
    return ((a[DW-1] ^ b[DW-1]) == sub) && (r[DW-1] != a[DW-1]);
  endfunction

endpackage

// File: rtl/up_ram32x8.sv
// Program/data RAM: combinational reads (operand port and fetch port), one synchronous write port.
// Contents survive reset so a host-loaded program is kept across CPU resets.
module up_ram32x8 #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic [AW-1:0] faddr,
  output logic [DW-1:0] fdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array has no reset on purpose; resetting it would erase the program and
  // turn the RAM into a huge flop bank instead of a memory macro.
  // NOTE: sequential state is written with <= so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
  assign fdata = mem[faddr];

endmodule

// File: rtl/up_datapath.sv
// Accumulator datapath (PC, IR, A, MDR, RAM) steered by the control unit's control word.
// Optional sticky signed-overflow output OVF is built when UP_DP_OVF_EN is defined.
module up_datapath
  import up_pkg::*;
#(
  parameter int DW = up_pkg::DW,
  parameter int AW = up_pkg::AW
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  input  logic          IRload,
  input  logic          JMPmux,
  input  logic          PCload,
  input  logic          Meminst,
  input  logic          MemWr,
  input  logic          Aload,
  input  logic          Sub,
  input  logic [1:0]    Asel,
  input  logic          Halt,
  input  logic [DW-1:0] DIN,
  input  logic          PWE,
  input  logic [AW-1:0] PADDR,
  input  logic [DW-1:0] PDATA,
  output logic [2:0]    IR_OP,
  output logic          Aeq0,
  output logic          Apos,
  output logic [DW-1:0] DOUT,
  output logic [AW-1:0] PC_OUT,
  output logic          HALTED
`ifdef UP_DP_OVF_EN
  ,
  output logic          OVF
`endif
);

  logic [AW-1:0] pc;
  logic [DW-1:0] ir;
  logic [DW-1:0] a;
  logic [DW-1:0] mdr;
  logic          halted;

  logic [AW-1:0] ir_addr;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] ram_fdata;
  logic [DW-1:0] alu;
  logic [DW-1:0] a_next;
  asel_t         asel;

  assign ir_addr  = ir[AW-1:0];
  assign ram_addr = Meminst ? ir_addr : pc;
  assign asel     = asel_t'(Asel);

  // Host load has priority over a STORE; neither a halted CPU nor reset may store A.
  assign ram_we    = RESET_N & (PWE | (MemWr & ~Halt));
  assign ram_waddr = PWE ? PADDR : ram_addr;
  assign ram_wdata = PWE ? PDATA : a;

  up_ram32x8 #(.DW(DW), .AW(AW)) u_ram (
    .clk   (CLOCK),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_addr),
    .rdata (ram_rdata),
    .faddr (pc),
    .fdata (ram_fdata)
  );

  assign alu = Sub ? a - mdr : a + mdr;

  // NOTE: a_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    a_next = alu;
    unique case (asel)
      ASEL_ALU:  a_next = alu;
      ASEL_IN:   a_next = DIN;
      ASEL_MEM:  a_next = mdr;
      ASEL_ZERO: a_next = '0;
      default:   a_next = alu;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc     <= '0;
      ir     <= '0;
      a      <= '0;
      mdr    <= '0;
      halted <= 1'b0;
    end else begin
      halted <= halted | Halt;
      if (!Halt) begin
        if (IRload)             ir  <= ram_fdata;
        if (PCload)             pc  <= JMPmux ? ir_addr : pc + AW'(1);
        if (Meminst && !MemWr)  mdr <= ram_rdata;
        if (Aload)              a   <= a_next;
      end
    end
  end

`ifdef UP_DP_OVF_EN
  logic ovf;
  logic alu_ovf;

  assign alu_ovf = add_sub_ovf(a, mdr, alu, Sub);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      ovf <= 1'b0;
    end else if (!Halt && Aload) begin
      if (asel == ASEL_ALU && alu_ovf) ovf <= 1'b1;
      else if (asel == ASEL_ZERO)      ovf <= 1'b0;
    end
  end

  assign OVF = ovf;
`endif

  assign IR_OP  = ir[DW-1:DW-3];
  assign Aeq0   = (a == '0);
  assign Apos   = ~a[DW-1];
  assign DOUT   = a;
  assign PC_OUT = pc;
  assign HALTED = halted;

endmodule

// File: tb/tb_up_datapath.sv
// Scoreboard bench for up_datapath: a behavioural model pushes expected state per cycle,
// directed program sequences add fixed expectations, then a random control-word soak.
module tb_up_datapath;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, PWE;
  logic [1:0] Asel;
  logic [7:0] DIN, PDATA;
  logic [4:0] PADDR;
  logic [2:0] IR_OP;
  logic       Aeq0, Apos, HALTED;
  logic [7:0] DOUT;
  logic [4:0] PC_OUT;
`ifdef UP_DP_OVF_EN
  logic       OVF;
`endif

  up_datapath dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
    .Meminst(Meminst), .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Asel(Asel), .Halt(Halt),
    .DIN(DIN), .PWE(PWE), .PADDR(PADDR), .PDATA(PDATA), .IR_OP(IR_OP), .Aeq0(Aeq0),
    .Apos(Apos), .DOUT(DOUT), .PC_OUT(PC_OUT), .HALTED(HALTED)
`ifdef UP_DP_OVF_EN
    , .OVF(OVF)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic       ir_load, jmp, pc_load, meminst, mem_wr, a_load, sub;
    logic [1:0] asel;
    logic       halt;
    logic [7:0] din;
    logic       pwe;
    logic [4:0] paddr;
    logic [7:0] pdata;
  } ctrl_t;

  typedef enum {K_A, K_PC, K_OP, K_EQ0, K_POS, K_HALTED, K_OVF} kind_t;
  typedef struct { string tag; kind_t kind; logic [7:0] val; } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;

  logic [7:0] mem_m [32];
  logic [7:0] a_m, ir_m, mdr_m;
  logic [4:0] pc_m;
  logic       halted_m, ovf_m;

  task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %02h, expected %02h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] observe(input kind_t k);
    case (k)
      K_A:      return DOUT;
      K_PC:     return {3'b0, PC_OUT};
      K_OP:     return {5'b0, IR_OP};
      K_EQ0:    return {7'b0, Aeq0};
      K_POS:    return {7'b0, Apos};
      K_HALTED: return {7'b0, HALTED};
`ifdef UP_DP_OVF_EN
      K_OVF:    return {7'b0, OVF};
`endif
      default:  return 8'hxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input kind_t k, input logic [7:0] v);
    sb.push_back('{tag, k, v});
  endtask

  task automatic push_model(input string tag);
    expect_val({tag, ".A"},      K_A,      a_m);
    expect_val({tag, ".PC"},     K_PC,     {3'b0, pc_m});
    expect_val({tag, ".IR_OP"},  K_OP,     {5'b0, ir_m[7:5]});
    expect_val({tag, ".Aeq0"},   K_EQ0,    {7'b0, a_m == 8'h00});
    expect_val({tag, ".Apos"},   K_POS,    {7'b0, a_m < 8'h80});
    expect_val({tag, ".HALTED"}, K_HALTED, {7'b0, halted_m});
`ifdef UP_DP_OVF_EN
    expect_val({tag, ".OVF"},    K_OVF,    {7'b0, ovf_m});
`endif
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, observe(e.kind), e.val);
    end
  endtask

  task automatic drive(input ctrl_t c);
    IRload = c.ir_load;  JMPmux = c.jmp;     PCload = c.pc_load; Meminst = c.meminst;
    MemWr  = c.mem_wr;   Aload  = c.a_load;  Sub    = c.sub;     Asel    = c.asel;
    Halt   = c.halt;     DIN    = c.din;     PWE    = c.pwe;     PADDR   = c.paddr;
    PDATA  = c.pdata;
  endtask

  task automatic model_reset();
    a_m = 8'h00; ir_m = 8'h00; mdr_m = 8'h00; pc_m = 5'd0; halted_m = 1'b0; ovf_m = 1'b0;
  endtask

  // One clock: drive controls, advance the model, queue expectations, check after the edge.
  task automatic cycle(input ctrl_t c, input string tag);
    logic [4:0] addr, pc_n;
    logic [7:0] a_n, ir_n, mdr_n;
    logic       ovf_n;
    int         s;
    drive(c);
    addr = c.meminst ? ir_m[4:0] : pc_m;
    a_n = a_m; ir_n = ir_m; mdr_n = mdr_m; pc_n = pc_m; ovf_n = ovf_m;
    if (!c.halt) begin
      if (c.ir_load) ir_n = mem_m[pc_m];
      if (c.pc_load) pc_n = c.jmp ? ir_m[4:0] : pc_m + 5'd1;
      if (c.meminst && !c.mem_wr) mdr_n = mem_m[ir_m[4:0]];
      if (c.a_load) begin
        case (c.asel)
          2'b00: begin
            s   = c.sub ? int'($signed(a_m)) - int'($signed(mdr_m))
                        : int'($signed(a_m)) + int'($signed(mdr_m));
            a_n = c.sub ? a_m - mdr_m : a_m + mdr_m;
            if (s > 127 || s < -128) ovf_n = 1'b1;
          end
          2'b01:   a_n = c.din;
          2'b10:   a_n = mdr_m;
          default: begin a_n = 8'h00; ovf_n = 1'b0; end
        endcase
      end
    end
    if (c.pwe) mem_m[c.paddr] = c.pdata;
    else if (c.mem_wr && !c.halt) mem_m[addr] = a_m;
    halted_m = halted_m | c.halt;
    a_m = a_n; ir_m = ir_n; mdr_m = mdr_n; pc_m = pc_n; ovf_m = ovf_n;
    push_model(tag);
    @(posedge CLOCK);
    #1;
    drain();
  endtask

  function automatic ctrl_t c_fetch();
    ctrl_t c = '0; c.ir_load = 1'b1; c.pc_load = 1'b1; return c;
  endfunction
  function automatic ctrl_t c_decode();
    ctrl_t c = '0; c.meminst = 1'b1; return c;
  endfunction
  function automatic ctrl_t c_aload(input logic [1:0] asel, input logic sub, input logic [7:0] din);
    ctrl_t c = '0; c.a_load = 1'b1; c.asel = asel; c.sub = sub; c.din = din; return c;
  endfunction
  function automatic ctrl_t c_pc(input logic pc_load, input logic jmp);
    ctrl_t c = '0; c.pc_load = pc_load; c.jmp = jmp; return c;
  endfunction
  function automatic ctrl_t c_pwrite(input logic [4:0] addr, input logic [7:0] data);
    ctrl_t c = '0; c.pwe = 1'b1; c.paddr = addr; c.pdata = data; return c;
  endfunction

  initial begin
    ctrl_t c;
    logic [7:0] prog [32];

    drive('0);
    model_reset();
    repeat (2) @(posedge CLOCK);
    #1;
    expect_val("rst.A", K_A, 8'h00);
    expect_val("rst.PC", K_PC, 8'h00);
    expect_val("rst.IR_OP", K_OP, 8'h00);
    expect_val("rst.Aeq0", K_EQ0, 8'h01);
    expect_val("rst.Apos", K_POS, 8'h01);
    expect_val("rst.HALTED", K_HALTED, 8'h00);
    drain();
    @(negedge CLOCK);
    RESET_N = 1'b1;

    // Program image; unused words get random fill.
    for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
    prog[0] = 8'h1E; prog[1] = 8'h5F; prog[2] = 8'h7D; prog[3] = 8'hB4;
    prog[20] = 8'hBF; prog[29] = 8'h01; prog[30] = 8'h05; prog[31] = 8'h07;
    for (int i = 0; i < 32; i++) cycle(c_pwrite(5'(i), prog[i]), "load");

    // LOAD 30
    expect_val("load.IR_OP", K_OP, 8'h00);
    expect_val("load.PC", K_PC, 8'h01);
    cycle(c_fetch(), "fetch0");
    cycle(c_decode(), "decode0");
    expect_val("load.A", K_A, 8'h05);
    cycle(c_aload(2'b10, 1'b0, 8'h00), "exec_load");

    // ADD 31 then SUB with the same MDR
    cycle(c_fetch(), "fetch1");
    cycle(c_decode(), "decode1");
    expect_val("add.A", K_A, 8'h0C);
    cycle(c_aload(2'b00, 1'b0, 8'h00), "exec_add");
    expect_val("sub.A", K_A, 8'h05);
    cycle(c_aload(2'b00, 1'b1, 8'h00), "exec_sub");

    // 0 - 1 borrows to 0xFF
    cycle(c_fetch(), "fetch2");
    cycle(c_decode(), "decode2");
    cycle(c_aload(2'b11, 1'b0, 8'h00), "clr");
    expect_val("borrow.A", K_A, 8'hFF);
    expect_val("borrow.Apos", K_POS, 8'h00);
    cycle(c_aload(2'b00, 1'b1, 8'h00), "exec_borrow");

    // JZ 20 taken with A=0, held when PCload=0
    cycle(c_fetch(), "fetch3");
    cycle(c_aload(2'b11, 1'b0, 8'h00), "clr2");
    expect_val("jz.PC", K_PC, 8'd20);
    cycle(c_pc(1'b1, 1'b1), "jump");
    cycle(c_aload(2'b01, 1'b0, 8'h01), "in1");
    expect_val("nojump.PC", K_PC, 8'd20);
    cycle(c_pc(1'b0, 1'b1), "nojump");

    // Jump to 31, then fetch wraps PC to 0
    cycle(c_fetch(), "fetch20");
    cycle(c_pc(1'b1, 1'b1), "jump31");
    expect_val("wrap.PC", K_PC, 8'd0);
    cycle(c_fetch(), "fetch31");

    // Host write beats a same-cycle STORE to the same address
    repeat (3) cycle(c_pc(1'b1, 1'b0), "inc");
    cycle(c_aload(2'b01, 1'b0, 8'h11), "in11");
    c = c_pwrite(5'd3, 8'hAA);
    c.mem_wr = 1'b1;
    cycle(c, "pwe_vs_memwr");
    expect_val("prio.IR_OP", K_OP, 8'h05);
    cycle(c_fetch(), "fetch_prio");

    // STORE to IR[4:0]=10 leaves MDR alone; readback through MDR
    c = c_decode();
    c.mem_wr = 1'b1;
    cycle(c, "store");
    expect_val("store_mdr.A", K_A, 8'h01);
    cycle(c_aload(2'b10, 1'b0, 8'h00), "mdr_kept");
    cycle(c_decode(), "decode10");
    expect_val("store_rb.A", K_A, 8'h11);
    cycle(c_aload(2'b10, 1'b0, 8'h00), "store_rb");

    // INPUT wait: A follows DIN every cycle
    for (int i = 0; i < 4; i++) cycle(c_aload(2'b01, 1'b0, 8'($urandom)), "din_track");

    // Mid-run reset with A=0x5A, PC=7; PWE during reset must be ignored
    repeat (3) cycle(c_pc(1'b1, 1'b0), "inc7");
    cycle(c_aload(2'b01, 1'b0, 8'h5A), "in5a");
    RESET_N = 1'b0;
    drive(c_pwrite(5'd0, 8'hFF));
    #2;
    model_reset();
    expect_val("mid_rst.A", K_A, 8'h00);
    expect_val("mid_rst.PC", K_PC, 8'h00);
    expect_val("mid_rst.Aeq0", K_EQ0, 8'h01);
    push_model("mid_rst");
    drain();
    @(posedge CLOCK);
    @(negedge CLOCK);
    drive('0);
    RESET_N = 1'b1;
    expect_val("ram_kept.IR_OP", K_OP, 8'h00);
    cycle(c_fetch(), "fetch_after_rst");

    // Halt freezes registers and STORE; host write still lands
    cycle(c_aload(2'b01, 1'b0, 8'h33), "in33");
    c = c_fetch();
    c.halt = 1'b1; c.a_load = 1'b1; c.asel = 2'b01; c.din = 8'h44; c.mem_wr = 1'b1;
    c.pwe = 1'b1; c.paddr = 5'd2; c.pdata = 8'h66;
    expect_val("halt.A", K_A, 8'h33);
    expect_val("halt.PC", K_PC, 8'h01);
    expect_val("halt.HALTED", K_HALTED, 8'h01);
    cycle(c, "halt");
    expect_val("halt_sticky", K_HALTED, 8'h01);
    cycle('0, "after_halt");
    expect_val("halt_nostore.IR_OP", K_OP, 8'h02);
    cycle(c_fetch(), "fetch_h1");
    expect_val("halt_pwe.IR_OP", K_OP, 8'h03);
    cycle(c_fetch(), "fetch_h2");

    // Signed overflow 0x7F + 0x01, sticky, then cleared by Asel=11
    cycle(c_pwrite(5'd6, 8'h01), "mdr1");
    cycle(c_decode(), "decode6");
    cycle(c_aload(2'b01, 1'b0, 8'h7F), "in7f");
    expect_val("ovf.A", K_A, 8'h80);
`ifdef UP_DP_OVF_EN
    expect_val("ovf.set", K_OVF, 8'h01);
`endif
    cycle(c_aload(2'b00, 1'b0, 8'h00), "ovf_add");
`ifdef UP_DP_OVF_EN
    expect_val("ovf.sticky", K_OVF, 8'h01);
`endif
    cycle(c_aload(2'b00, 1'b0, 8'h00), "ovf_add2");
`ifdef UP_DP_OVF_EN
    expect_val("ovf.clear", K_OVF, 8'h00);
`endif
    cycle(c_aload(2'b11, 1'b0, 8'h00), "ovf_clr");

    // Random control words
    for (int i = 0; i < 300; i++) begin
      c = ctrl_t'($urandom);
      c.halt = ($urandom_range(0, 15) == 0);
      c.pwe  = ($urandom_range(0, 3) == 0);
      cycle(c, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
